// File: rtl/nes_pad_responder.sv
// NES controller device-side emulator: answers host latch/clock pulses on the
// serial data pin with eight active-low button bits, and counts completed polls.
module nes_pad_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        latch_in,
  input  logic        pclk_in,
  input  logic [7:0]  buttons,
  output logic        data_out,
  output logic        frame_done,
  output logic        over_read,
  output logic [15:0] poll_count
);

  localparam int unsigned NBITS = 8;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] latch_sync;
  logic [SYNC_STAGES-1:0] pclk_sync;
  logic                   latch_hist;
  logic                   pclk_hist;
  logic                   latch_s;
  logic                   pclk_s;
  logic                   latch_rise;
  logic                   latch_fall;
  logic                   pclk_rise;

  logic [NBITS-1:0] sreg, sreg_nxt;
  logic [IDX_W-1:0] bit_idx, bit_idx_nxt;
  logic             data_out_nxt;
  logic             frame_done_nxt;
  logic             over_read_nxt;
  logic [CNT_W-1:0] poll_count_nxt;

  // Host pin synchronizers followed by a history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_sync <= '0;
      pclk_sync  <= '0;
      latch_hist <= 1'b0;
      pclk_hist  <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch_in};
      pclk_sync  <= {pclk_sync[SYNC_STAGES-2:0], pclk_in};
      latch_hist <= latch_s;
      pclk_hist  <= pclk_s;
    end
  end

  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign pclk_s     = pclk_sync[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_hist;
  assign latch_fall = ~latch_s & latch_hist;
  assign pclk_rise  = pclk_s & ~pclk_hist;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a latch rise always restarts the frame
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (latch_rise) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (latch_fall) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (latch_rise) begin
          state_nxt = S_LOAD;
        end else if (pclk_rise && (bit_idx == LAST_IDX)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (latch_rise) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and output next values; data_out mirrors the next sreg MSB so
  // it lags buttons by only one register while latched
  always_comb begin
    sreg_nxt       = sreg;
    bit_idx_nxt    = bit_idx;
    frame_done_nxt = 1'b0;
    over_read_nxt  = 1'b0;
    poll_count_nxt = poll_count;

    if (latch_rise) begin
      sreg_nxt    = ~buttons;
      bit_idx_nxt = '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (latch_s) begin
            sreg_nxt = ~buttons;
          end else if (latch_fall) begin
            bit_idx_nxt = '0;
          end
        end
        S_SHIFT: begin
          if (pclk_rise) begin
            sreg_nxt    = {sreg[NBITS-2:0], 1'b1};
            bit_idx_nxt = bit_idx + IDX_W'(1);
            if (bit_idx == LAST_IDX) begin
              frame_done_nxt = 1'b1;
              poll_count_nxt = poll_count + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          if (pclk_rise) over_read_nxt = 1'b1;
        end
        default: ;
      endcase
    end

    if ((state_nxt == S_LOAD) || (state_nxt == S_SHIFT)) begin
      data_out_nxt = sreg_nxt[NBITS-1];
    end else begin
      data_out_nxt = 1'b1;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg       <= '1;
      bit_idx    <= '0;
      data_out   <= 1'b1;
      frame_done <= 1'b0;
      over_read  <= 1'b0;
      poll_count <= '0;
    end else begin
      sreg       <= sreg_nxt;
      bit_idx    <= bit_idx_nxt;
      data_out   <= data_out_nxt;
      frame_done <= frame_done_nxt;
      over_read  <= over_read_nxt;
      poll_count <= poll_count_nxt;
    end
  end

endmodule

// File: tb/tb_nes_pad_responder.sv
// Randomized bench for nes_pad_responder: drives host latch/clock levels and
// compares data_out and pulse/poll counts against a frame-level model.
module tb_nes_pad_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        latch_in = 1'b0;
  logic        pclk_in = 1'b0;
  logic [7:0]  buttons = 8'h00;
  logic        data_out;
  logic        frame_done;
  logic        over_read;
  logic [15:0] poll_count;

  nes_pad_responder #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .latch_in   (latch_in),
    .pclk_in    (pclk_in),
    .buttons    (buttons),
    .data_out   (data_out),
    .frame_done (frame_done),
    .over_read  (over_read),
    .poll_count (poll_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int lw      = 4;

  // Frame-level model: value latched, clocks received since the latch
  logic [7:0]  mdl_val = 8'hFF;
  int          mdl_k = 0;
  bit          mdl_in_frame = 1'b0;
  logic [15:0] mdl_polls = 16'd0;
  int          exp_fd = 0;
  int          exp_or = 0;
  int          seen_fd = 0;
  int          seen_or = 0;

  always @(negedge clk) begin
    if (frame_done === 1'b1) seen_fd++;
    if (over_read === 1'b1) seen_or++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_data();
    if (mdl_in_frame && (mdl_k < 8)) return !mdl_val[7 - mdl_k];
    return 1'b1;
  endfunction

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_latch(input logic [7:0] v, input bit with_clk);
    buttons  = v;
    latch_in = 1'b1;
    if (with_clk) pclk_in = 1'b1;
    hold(lw);
    check("load_track", 32'(data_out), 32'(!v[7]));
    latch_in = 1'b0;
    pclk_in  = 1'b0;
    hold(lw);
    mdl_val      = v;
    mdl_k        = 0;
    mdl_in_frame = 1'b1;
    check("first_bit", 32'(data_out), 32'(exp_data()));
  endtask

  task automatic pulse_clk();
    pclk_in = 1'b1;
    hold(lw);
    pclk_in = 1'b0;
    hold(lw);
    if (mdl_in_frame) begin
      if (mdl_k >= 8) begin
        exp_or++;
      end else begin
        mdl_k++;
        if (mdl_k == 8) begin
          exp_fd++;
          mdl_polls = mdl_polls + 16'd1;
        end
      end
    end
    check("bit", 32'(data_out), 32'(exp_data()));
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_frame_done"}, 32'(seen_fd), 32'(exp_fd));
    check({tag, "_over_read"}, 32'(seen_or), 32'(exp_or));
    check({tag, "_poll_count"}, 32'(poll_count), 32'(mdl_polls));
  endtask

  initial begin
    logic [7:0] v;
    int         nclk;

    // Reset state
    hold(3);
    check("rst_data_out", 32'(data_out), 32'(1'b1));
    check("rst_frame_done", 32'(frame_done), 32'(1'b0));
    check("rst_over_read", 32'(over_read), 32'(1'b0));
    check("rst_poll_count", 32'(poll_count), 32'(16'd0));
    rst_n = 1'b1;
    hold(3);
    check("idle_data_out", 32'(data_out), 32'(1'b1));

    // Full read with A and Right pressed
    lw = 4;
    do_latch(8'h81, 1'b0);
    for (int i = 0; i < 8; i++) pulse_clk();
    check_counters("full");

    // Live tracking while latched; clocks during latch do not shift
    lw = 5;
    buttons  = 8'h00;
    latch_in = 1'b1;
    hold(lw);
    check("live_0", 32'(data_out), 32'(1'b1));
    buttons[7] = 1'b1;
    hold(1);
    check("live_1", 32'(data_out), 32'(1'b0));
    hold(lw);
    buttons[7] = 1'b0;
    hold(1);
    check("live_2", 32'(data_out), 32'(1'b1));
    buttons = 8'hC3;
    hold(lw);
    pclk_in = 1'b1;
    hold(lw);
    pclk_in = 1'b0;
    hold(lw);
    check("live_clk_ignored", 32'(data_out), 32'(1'b0));
    latch_in = 1'b0;
    hold(lw);
    mdl_val      = 8'hC3;
    mdl_k        = 0;
    mdl_in_frame = 1'b1;
    check("live_first_bit", 32'(data_out), 32'(exp_data()));
    for (int i = 0; i < 8; i++) pulse_clk();
    check_counters("live");

    // Over-read
    for (int i = 0; i < 3; i++) pulse_clk();
    check_counters("over");

    // Aborted frame then a full re-read
    do_latch(8'hF0, 1'b0);
    for (int i = 0; i < 4; i++) pulse_clk();
    do_latch(8'h0F, 1'b0);
    for (int i = 0; i < 8; i++) pulse_clk();
    check_counters("abort");

    // Async reset mid-shift
    do_latch(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) pulse_clk();
    rst_n = 1'b0;
    #1;
    mdl_polls    = 16'd0;
    mdl_in_frame = 1'b0;
    check("arst_data_out", 32'(data_out), 32'(1'b1));
    check("arst_poll_count", 32'(poll_count), 32'(16'd0));
    @(negedge clk);
    rst_n = 1'b1;
    hold(2);
    for (int i = 0; i < 3; i++) pulse_clk();
    check_counters("arst");

    // Randomized frames: widths, button values, clock counts, aborts, latch+clock collisions
    for (int f = 0; f < 40; f++) begin
      lw   = int'($urandom_range(4, 7));
      v    = 8'($urandom);
      nclk = int'($urandom_range(0, 11));
      do_latch(v, ($urandom % 4) == 0);
      for (int i = 0; i < nclk; i++) pulse_clk();
    end
    check_counters("rand");

    // Counter wrap at minimum level width; preload just below wrap
    lw = 4;
    force dut.poll_count = 16'hFFFF;
    hold(1);
    release dut.poll_count;
    mdl_polls = 16'hFFFF;
    do_latch(8'h5A, 1'b0);
    for (int i = 0; i < 8; i++) pulse_clk();
    check_counters("wrap");
    do_latch(8'hA5, 1'b0);
    for (int i = 0; i < 8; i++) pulse_clk();
    check_counters("wrap_next");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
